// File: rtl/if_stage_ifid.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, drives the
// instruction-memory address and latches the fetched word plus PC+4 for decode.
module if_stage_ifid #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          HOLD_MAX = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        hold_PC,
    input  logic        hold_IFID,
    input  logic        Branch_Resolved,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Data,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [15:0] Stall_Count,
    output logic        Hold_Timeout,
    output logic        Dbg_State
);

    localparam int RUN_W = $clog2(HOLD_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HOLD_MAX);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [15:0]      stall_q, stall_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    logic        redirect;
    logic        hold_any;
    logic [31:0] pc_plus4;

    assign redirect = Branch_Resolved & Branch_Taken;
    assign hold_any = hold_PC | hold_IFID;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        valid_d   = valid_q;
        stall_d   = stall_q;
        run_d     = run_q;
        if (redirect) begin
            // A taken branch flushes IF/ID and wins over any hold request.
            pc_d    = {Branch_Target[31:2], 2'b00};
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            run_d   = '0;
            state_d = ST_RUN;
        end else begin
            if (!hold_PC) begin
                pc_d = pc_plus4;
            end
            if (!hold_IFID) begin
                if (hold_PC) begin
                    instr_d = NOP_WORD;
                    pc4_d   = 32'd0;
                    valid_d = 1'b0;
                end else begin
                    instr_d = IMem_Data;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            if (hold_PC && (stall_q != 16'hFFFF)) begin
                stall_d = stall_q + 16'd1;
            end
            if (hold_any) begin
                if (run_q != RUN_MAX) begin
                    run_d = run_q + RUN_W'(1);
                end
                state_d = ST_HOLD;
            end else begin
                run_d   = '0;
                state_d = ST_RUN;
            end
        end
        timeout_d = timeout_q | (run_d == RUN_MAX);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            pc4_q     <= 32'd0;
            valid_q   <= 1'b0;
            stall_q   <= 16'd0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign IMem_Addr        = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pc4_q;
    assign IFID_Valid       = valid_q;
    assign Stall_Count      = stall_q;
    assign Hold_Timeout     = timeout_q;
    assign Dbg_State        = (state_q == ST_HOLD);

endmodule

// File: doc/if_stage_ifid.md
Name: if_stage_ifid

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address. It latches the fetched word and PC+4 into IF/ID.
- Consumes hold_PC/hold_IFID from the hazard detection unit and a branch redirect from the branch-resolution logic.
- Sits directly upstream of ID and of the hazard detection unit, which reads IFID_Instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HOLD_MAX, 16, consecutive hold cycles after which Hold_Timeout sets.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble or flush.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- hold_PC  input  1  freeze PC this cycle
- hold_IFID  input  1  freeze IF/ID register this cycle
- Branch_Resolved  input  1  one-cycle pulse: a branch outcome is known
- Branch_Taken  input  1  qualifies Branch_Resolved; 1 = redirect
- Branch_Target  input  32  redirect address, word aligned
- IMem_Addr  output  32  instruction-memory address (= PC, combinational from PC register)
- IMem_Data  input  32  instruction word at IMem_Addr, same-cycle combinational read
- IFID_Instruction  output  32  registered instruction to ID / hazard unit
- IFID_PCPlus4  output  32  registered PC+4 of that instruction
- IFID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
- Stall_Count  output  16  saturating count of cycles with hold_PC=1
- Hold_Timeout  output  1  sticky: hold asserted HOLD_MAX consecutive cycles

Behaviour:
- Reset (async, Rst_n=0): PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, Stall_Count=0, hold run counter=0, Hold_Timeout=0, state=RUN. Release is sampled at the next Clk edge; the first fetch from RESET_PC happens on that edge.
- All state updates occur on the rising Clk edge. IMem_Addr=PC with no latency. The instruction fetched in cycle N appears on IFID_* in cycle N+1.
- FSM states: RUN, HOLD.
  - RUN -> HOLD when hold_PC|hold_IFID.
  - HOLD -> RUN when both are low.
  - Any redirect forces RUN.
- Priority per edge, highest first:
  1. Redirect: Branch_Resolved & Branch_Taken. PC<=Branch_Target; IFID_Instruction<=NOP_WORD; IFID_Valid<=0; IFID_PCPlus4<=0. Overrides both holds. The hold run counter clears.
  2. Not-taken resolution: Branch_Resolved & !Branch_Taken. No redirect; falls through to the hold rules.
  3. hold_PC=1, hold_IFID=1: PC and IF/ID unchanged.
  4. hold_PC=1, hold_IFID=0: PC unchanged; IF/ID loads NOP_WORD with Valid=0 (bubble insertion).
  5. hold_PC=0, hold_IFID=1: PC<=PC+4; IF/ID unchanged. The fetched word is discarded; this is the intended flush-skip behaviour.
  6. No hold: PC<=PC+4; IFID_Instruction<=IMem_Data; IFID_PCPlus4<=PC+4; IFID_Valid<=1.
- PC arithmetic is 32-bit modulo. PC=32'hFFFF_FFFC wraps to 0, and IFID_PCPlus4=0 in that case.
- Branch_Target bits [1:0] are ignored and forced to 00.
- Stall_Count increments on each edge with hold_PC=1 and no redirect. It saturates at 16'hFFFF and clears only on reset.
- Hold run counter:
  - Increments on each edge with hold_PC|hold_IFID and no redirect.
  - Clears on any edge with both holds low.
  - When it reaches HOLD_MAX, Hold_Timeout<=1; Hold_Timeout stays 1 until reset.
  - The counter saturates at HOLD_MAX.
- Reset mid-hold or mid-redirect: all outputs take their reset values immediately, asynchronously.

Test Plan:
1. Reset release, no holds, IMem returns 32'h2001_0005 for every address -> IMem_Addr steps 0,4,8,12. On the edge after the first fetch, IFID_Instruction=32'h2001_0005, IFID_PCPlus4=4, IFID_Valid=1.
2. PC=8 with hold_PC=hold_IFID=1 for 3 cycles -> IMem_Addr stays 8 and IF/ID is unchanged for 3 cycles. Stall_Count=3. When the holds drop, PC advances to 12.
3. PC=8 with hold_PC=1, hold_IFID=0 for 1 cycle -> IFID_Instruction=0, IFID_Valid=0, PC stays 8. The next cycle loads the word at 8 with IFID_PCPlus4=12.
4. Branch_Resolved=1, Branch_Taken=1, Branch_Target=32'h0000_0040 while hold_PC=hold_IFID=1 -> the redirect wins: PC=32'h40, IFID_Valid=0. The next free cycle fetches from 32'h40.
5. Both holds held for 16 consecutive cycles with HOLD_MAX=16 -> Hold_Timeout=1 after the 16th edge. It stays 1 after the holds drop and clears only when Rst_n=0.
6. PC=32'hFFFF_FFFC, no hold -> PC=0, IFID_PCPlus4=0. Then assert Rst_n=0 mid-cycle -> IFID_Valid=0 and PC=RESET_PC without waiting for a clock edge.
